// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame slave.
//   state_e    : frame FSM states
//   frame_bits : frame length in bits, 8 * max(rx_bytes, tx_bytes)
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int unsigned frame_bits(input int unsigned rx_bytes,
                                             input int unsigned tx_bytes);
    return 8 * ((rx_bytes > tx_bytes) ? rx_bytes : tx_bytes);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous input bit.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset; all stages take RST_VAL
//   i_d     : asynchronous input
//   o_q     : synchronised output (last stage)
module spi_sync
  import spi_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_frame_slave.sv
// SPI slave that exchanges fixed-length frames, oversampling the SPI bus
// with the system clock.
//   sysClk     : system clock (only clock in the block)
//   reset_n    : asynchronous active-low reset
//   spiClk     : SPI clock from master (asynchronous)
//   mosi       : master-out data, MSB first
//   cs         : active-low chip select
//   miso       : slave-out data, MSB first; 0 while cs is high
//   rx_data    : last complete received payload
//   rx_valid   : one-cycle pulse per completed frame
//   tx_data    : payload for the next frame
//   tx_load    : latch tx_data into the TX shadow (only while idle)
//   busy       : high while a frame is active
//   frame_err  : one-cycle pulse on a truncated frame
//   tx_overrun : one-cycle pulse when tx_load is rejected
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int unsigned RX_BYTES    = 4,
  parameter int unsigned TX_BYTES    = 4,
  parameter logic        CPOL        = 1'b0,
  parameter logic        CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    sysClk,
  input  logic                    reset_n,
  input  logic                    spiClk,
  input  logic                    mosi,
  input  logic                    cs,
  output logic                    miso,
  output logic [8*RX_BYTES-1:0]   rx_data,
  output logic                    rx_valid,
  input  logic [8*TX_BYTES-1:0]   tx_data,
  input  logic                    tx_load,
  output logic                    busy,
  output logic                    frame_err,
  output logic                    tx_overrun
);

  localparam int unsigned FB  = frame_bits(RX_BYTES, TX_BYTES);
  localparam int unsigned RXW = 8 * RX_BYTES;
  localparam int unsigned TXW = 8 * TX_BYTES;
  localparam int unsigned CW  = $clog2(FB + 1);

  logic w_sclk_s, w_mosi_s, w_cs_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .i_clk(sysClk), .i_rst_n(reset_n), .i_d(spiClk), .o_q(w_sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(sysClk), .i_rst_n(reset_n), .i_d(mosi), .o_q(w_mosi_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(sysClk), .i_rst_n(reset_n), .i_d(cs), .o_q(w_cs_s)
  );

  state_e           r_state;
  logic             r_sclk_d;
  logic             r_cs_d;
  logic [1:0]       r_flush;
  logic             r_armed;
  logic [RXW-1:0]   r_rx_sr;
  logic [FB-1:0]    r_tx_sr;
  logic [TXW-1:0]   r_shadow;
  logic [CW-1:0]    r_cnt;
  logic             r_miso;
  logic [RXW-1:0]   r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_tx_overrun;

  logic             w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic             w_sample, w_shift;
  logic             w_flush_done, w_cs_fall;
  logic [TXW-1:0]   w_tx_src;
  logic [FB-1:0]    w_tx_frame;
  logic [RXW-1:0]   w_rx_next;

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = CPHA ? w_trail : w_lead;
  assign w_shift     = CPHA ? w_lead : w_trail;

  // The synchroniser holds reset values for SYNC_STAGES cycles after reset;
  // only once real samples have arrived and cs has been seen high is a
  // cs fall trusted, so a frame already running at reset release is skipped.
  assign w_flush_done = (r_flush == 2'(SYNC_STAGES));
  assign w_cs_fall    = r_armed & r_cs_d & ~w_cs_s;

  // A load coinciding with frame start is used directly for that frame.
  assign w_tx_src  = tx_load ? tx_data : r_shadow;
  assign w_rx_next = {r_rx_sr[RXW-2:0], w_mosi_s};

  always_comb begin
    w_tx_frame = '0;
    w_tx_frame[FB-1 -: TXW] = w_tx_src;
  end

  always_ff @(posedge sysClk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_sclk_d     <= CPOL;
      r_cs_d       <= 1'b1;
      r_flush      <= '0;
      r_armed      <= 1'b0;
      r_rx_sr      <= '0;
      r_tx_sr      <= '0;
      r_shadow     <= '0;
      r_cnt        <= '0;
      r_miso       <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_tx_overrun <= 1'b0;
    end else begin
      r_sclk_d     <= w_sclk_s;
      r_cs_d       <= w_cs_s;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_tx_overrun <= tx_load && (r_state != ST_IDLE);

      if (!w_flush_done) begin
        r_flush <= r_flush + 2'd1;
      end
      if (w_flush_done && w_cs_s) begin
        r_armed <= 1'b1;
      end

      if (tx_load && (r_state == ST_IDLE)) begin
        r_shadow <= tx_data;
      end

      case (r_state)
        ST_IDLE: begin
          r_miso <= 1'b0;
          if (w_cs_fall) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_rx_sr <= '0;
            // CPHA=0 presents the MSB immediately; CPHA=1 waits for the
            // first leading edge to shift it out.
            if (CPHA) begin
              r_tx_sr <= w_tx_frame;
            end else begin
              r_miso  <= w_tx_frame[FB-1];
              r_tx_sr <= w_tx_frame << 1;
            end
          end
        end
        ST_SHIFT: begin
          if (w_cs_s) begin
            r_state     <= ST_IDLE;
            r_frame_err <= 1'b1;
            r_miso      <= 1'b0;
          end else begin
            if (w_shift) begin
              r_miso  <= r_tx_sr[FB-1];
              r_tx_sr <= r_tx_sr << 1;
            end
            if (w_sample) begin
              r_rx_sr <= w_rx_next;
              r_cnt   <= r_cnt + CW'(1);
              if (r_cnt == CW'(FB - 1)) begin
                r_state    <= ST_DONE;
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
                r_miso     <= 1'b0;
              end
            end
          end
        end
        ST_DONE: begin
          r_miso <= 1'b0;
          if (w_cs_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign miso       = r_miso & ~cs;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign busy       = (r_state != ST_IDLE);
  assign frame_err  = r_frame_err;
  assign tx_overrun = r_tx_overrun;

endmodule
